// File: rtl/pkt_xbar.sv
// pkt_xbar: 4x4 packet crossbar for the PU ring.
// Each input buffers packets in its own FIFO. Only the FIFO head competes,
// for the output named in its destination field. Each output runs its own
// round-robin arbiter. Granted heads are popped and land on the registered
// rx bus for exactly one cycle.
module pkt_xbar #(
  parameter int PKTW  = 15,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PKTW:0] tx0,
  input  logic [PKTW:0] tx1,
  input  logic [PKTW:0] tx2,
  input  logic [PKTW:0] tx3,
  output logic [PKTW:0] rx0,
  output logic [PKTW:0] rx1,
  output logic [PKTW:0] rx2,
  output logic [PKTW:0] rx3,
  output logic [3:0]    ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [PKTW:0] tx   [4];
  logic [PKTW:0] mem  [4][DEPTH];
  logic [AW-1:0] wptr [4];
  logic [AW-1:0] rptr [4];
  logic [AW:0]   cnt  [4];
  logic [1:0]    rr   [4];
  logic [PKTW:0] rx_p1 [4];
  logic [PKTW:0] head [4];
  logic [3:0]    req  [4];
  logic [1:0]    win  [4];
  logic [3:0]    gnt_vld;
  logic [3:0]    pop;
  logic [3:0]    push;
  logic [3:0]    drop;

  function automatic logic [1:0] dest_of(input logic [PKTW:0] p);
    return p[PKTW-1:PKTW-2];
  endfunction

  assign tx[0] = tx0;
  assign tx[1] = tx1;
  assign tx[2] = tx2;
  assign tx[3] = tx3;
  assign rx0   = rx_p1[0];
  assign rx1   = rx_p1[1];
  assign rx2   = rx_p1[2];
  assign rx3   = rx_p1[3];

  // Head entry of each FIFO and the output it requests (req[m][n]: input n wants output m)
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      head[n] = mem[n][rptr[n]];
    end
    for (int m = 0; m < 4; m++) begin
      req[m] = '0;
      for (int n = 0; n < 4; n++) begin
        req[m][n] = (cnt[n] != '0) && (dest_of(head[n]) == 2'(m));
      end
    end
  end

  // Per-output round-robin: first requester at or after the pointer, with wrap
  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    gnt_vld = '0;
    pop     = '0;
    for (int m = 0; m < 4; m++) begin
      win[m] = '0;
      for (int k = 0; k < 4; k++) begin
        idx = rr[m] + 2'(k);
        if (!gnt_vld[m] && req[m][idx]) begin
          gnt_vld[m] = 1'b1;
          win[m]     = idx;
        end
      end
      if (gnt_vld[m]) begin
        pop[win[m]] = 1'b1;
      end
    end
  end

  // Accept a valid packet unless the FIFO is full and is not draining this cycle
  always_comb begin
    push = '0;
    drop = '0;
    for (int n = 0; n < 4; n++) begin
      if (tx[n][PKTW]) begin
        if ((cnt[n] != (AW+1)'(DEPTH)) || pop[n]) begin
          push[n] = 1'b1;
        end else begin
          drop[n] = 1'b1;
        end
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow flags
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (rst) begin
        wptr[n] <= '0;
        rptr[n] <= '0;
        cnt[n]  <= '0;
        ovf[n]  <= 1'b0;
      end else begin
        if (pop[n]) begin
          rptr[n] <= rptr[n] + 1'b1;
        end
        if (push[n]) begin
          wptr[n] <= wptr[n] + 1'b1;
        end
        cnt[n] <= cnt[n] + (AW+1)'(push[n]) - (AW+1)'(pop[n]);
        if (drop[n]) begin
          ovf[n] <= 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents are meaningless while empty, so no reset is needed
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (push[n] && !rst) begin
        mem[n][wptr[n]] <= tx[n];
      end
    end
  end

  // Arbiter pointers and registered outputs: winner+1 after a grant, zero bus when idle
  always_ff @(posedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rst) begin
        rr[m]    <= '0;
        rx_p1[m] <= '0;
      end else begin
        if (gnt_vld[m]) begin
          rr[m] <= win[m] + 2'd1;
        end
        rx_p1[m] <= gnt_vld[m] ? head[win[m]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_pkt_xbar.sv
// Self-checking bench for pkt_xbar: a queue-based reference model tracks
// every input FIFO and output pointer. Directed scenarios are followed by
// randomized traffic with occasional resets.
module tb_pkt_xbar;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [15:0] tx0, tx1, tx2, tx3;
  logic [15:0] rx0, rx1, rx2, rx3;
  logic [3:0]  ovf;

  pkt_xbar #(.PKTW(15), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .tx0(tx0), .tx1(tx1), .tx2(tx2), .tx3(tx3),
    .rx0(rx0), .rx1(rx1), .rx2(rx2), .rx3(rx3),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  logic [15:0] q [4][$];
  int          mptr [4];
  logic [15:0] exp_rx [4];
  logic [3:0]  exp_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int dst, input int pay);
    logic [15:0] p;
    p = {1'b1, 2'(dst), 13'(pay)};
    return p;
  endfunction

  // Reference behaviour for one rising edge, from the current tx/rst values
  task automatic model_edge();
    logic [15:0] txv [4];
    int          w [4];
    logic [15:0] h;
    txv[0] = tx0; txv[1] = tx1; txv[2] = tx2; txv[3] = tx3;
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        q[n].delete();
        mptr[n]   = 0;
        exp_rx[n] = '0;
      end
      exp_ovf = '0;
    end else begin
      for (int m = 0; m < 4; m++) begin
        w[m] = -1;
        for (int k = 0; k < 4; k++) begin
          int i;
          i = (mptr[m] + k) % 4;
          if (w[m] < 0 && q[i].size() > 0) begin
            h = q[i][0];
            if (int'(h[14:13]) == m) w[m] = i;
          end
        end
      end
      for (int m = 0; m < 4; m++) begin
        if (w[m] >= 0) begin
          exp_rx[m] = q[w[m]].pop_front();
          mptr[m]   = (w[m] + 1) % 4;
        end else begin
          exp_rx[m] = '0;
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (txv[n][15]) begin
          if (q[n].size() < DEPTH) q[n].push_back(txv[n]);
          else exp_ovf[n] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("rx0", {16'h0, rx0}, {16'h0, exp_rx[0]});
    check_eq("rx1", {16'h0, rx1}, {16'h0, exp_rx[1]});
    check_eq("rx2", {16'h0, rx2}, {16'h0, exp_rx[2]});
    check_eq("rx3", {16'h0, rx3}, {16'h0, exp_rx[3]});
    check_eq("ovf", {28'h0, ovf}, {28'h0, exp_ovf});
  endtask

  task automatic set_tx(input logic [15:0] a, b, c, d);
    tx0 = a; tx1 = b; tx2 = c; tx3 = d;
  endtask

  task automatic idle(input int n);
    set_tx('0, '0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_tx('0, '0, '0, '0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int ta, tb_;
    int last0, last2;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    set_tx('0, '0, '0, '0);
    step();
    step();
    rst = 1'b0;
    check_eq("rst_rx", {rx0, rx1}, 32'h0);
    check_eq("rst_ovf", {28'h0, ovf}, 32'h0);

    // Single packet, two-edge latency, one-cycle pulse
    set_tx('0, mk(2, 13'h155), '0, '0);
    step();
    set_tx('0, '0, '0, '0);
    step();
    check_eq("single_rx2", {16'h0, rx2}, 32'h0000C155);
    check_eq("single_oth", {rx0, rx1}, 32'h0);
    check_eq("single_rx3", {16'h0, rx3}, 32'h0);
    step();
    check_eq("single_gone", {16'h0, rx2}, 32'h0);
    idle(2);

    // Four-way contention on output 3
    set_tx(mk(3, 10), mk(3, 11), mk(3, 12), mk(3, 13));
    step();
    idle(1);
    for (int i = 0; i < 4; i++) begin
      check_eq("cont_rx3", {16'h0, rx3}, {16'h0, mk(3, 10 + i)});
      step();
    end
    check_eq("cont_done", {16'h0, rx3}, 32'h0);
    idle(2);
    // Pointer back at 0: input 1 beats input 3
    set_tx('0, mk(3, 21), '0, mk(3, 23));
    step();
    idle(1);
    check_eq("ptr3_zero", {16'h0, rx3}, {16'h0, mk(3, 21)});
    idle(3);

    // Parallel permutation, all outputs in the same cycle
    set_tx(mk(1, 30), mk(0, 31), mk(3, 32), mk(2, 33));
    step();
    idle(1);
    check_eq("par_rx0", {16'h0, rx0}, {16'h0, mk(0, 31)});
    check_eq("par_rx1", {16'h0, rx1}, {16'h0, mk(1, 30)});
    check_eq("par_rx2", {16'h0, rx2}, {16'h0, mk(2, 33)});
    check_eq("par_rx3", {16'h0, rx3}, {16'h0, mk(3, 32)});
    idle(2);

    // Head-of-line blocking on input 0
    do_reset();
    set_tx('0, mk(1, 40), '0, '0);
    step();
    set_tx(mk(1, 41), '0, mk(1, 42), mk(1, 43));
    step();
    set_tx(mk(2, 44), '0, '0, '0);
    step();
    set_tx('0, '0, '0, '0);
    ta = -1; tb_ = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rx1 == mk(1, 41)) ta = i;
      if (rx2 == mk(2, 44)) tb_ = i;
    end
    check_eq("hol_seen", {31'h0, (ta >= 0 && tb_ >= 0)}, 32'h1);
    check_eq("hol_order", {31'h0, (tb_ > ta)}, 32'h1);

    // Overflow: two inputs stream into output 1
    do_reset();
    last0 = -1; last2 = -1;
    for (int i = 0; i < 30; i++) begin
      if (i < 12) set_tx(mk(1, i), '0, mk(1, 13'h100 + i), '0);
      else set_tx('0, '0, '0, '0);
      step();
      if (rx1[15]) begin
        if (rx1[8]) begin
          check_eq("ovf_ord2", {31'h0, (int'(rx1[7:0]) > last2)}, 32'h1);
          last2 = int'(rx1[7:0]);
        end else begin
          check_eq("ovf_ord0", {31'h0, (int'(rx1[7:0]) > last0)}, 32'h1);
          last0 = int'(rx1[7:0]);
        end
      end
      if (i == 12) check_eq("ovf_set", {28'h0, ovf}, 32'h5);
    end
    check_eq("ovf_sticky", {28'h0, ovf}, 32'h5);

    // Reset with packets still buffered; tx during reset is discarded
    set_tx(mk(0, 50), mk(0, 51), mk(0, 52), mk(0, 53));
    step();
    set_tx('0, '0, '0, '0);
    step();
    rst = 1'b1;
    set_tx(mk(1, 60), '0, '0, '0);
    step();
    rst = 1'b0;
    set_tx('0, '0, '0, '0);
    check_eq("rrst_rx", {rx0, rx1}, 32'h0);
    check_eq("rrst_rx23", {rx2, rx3}, 32'h0);
    check_eq("rrst_ovf", {28'h0, ovf}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("rrst_quiet", {rx0 | rx1, rx2 | rx3}, 32'h0);
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] r [4];
      for (int n = 0; n < 4; n++) begin
        r[n] = 16'($urandom);
        if ($urandom_range(0, 99) < 45) r[n][15] = 1'b1;
        else r[n][15] = 1'b0;
        if ($urandom_range(0, 3) == 0) r[n][14:13] = 2'd2;
      end
      set_tx(r[0], r[1], r[2], r[3]);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
